// File: rtl/shadow1229_tone_decoder.sv
// Recovers note events (period, cycle count) from the player's 1-bit speaker square wave.
// It measures rising-edge periods, groups runs of equal periods into notes, and emits them over valid/ready.
module shadow1229_tone_decoder #(
    parameter int PERIOD_W       = 10,
    parameter int COUNT_W        = 16,
    parameter int SILENCE_CYCLES = 600,
    parameter int TOL            = 1,
    parameter int MIN_PERIODS    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spk_in,
    input  logic                ev_ready,
    output logic                ev_valid,
    output logic [PERIOD_W-1:0] ev_period,
    output logic [COUNT_W-1:0]  ev_count,
    output logic                idle,
    output logic                overflow
);

    localparam logic [PERIOD_W-1:0]      PMAX    = '1;
    localparam logic [PERIOD_W-1:0]      SIL_VAL = PERIOD_W'(SILENCE_CYCLES);
    localparam logic [COUNT_W-1:0]       CMAX    = '1;
    localparam logic [COUNT_W-1:0]       MIN_RUN = COUNT_W'(MIN_PERIODS);
    localparam logic signed [PERIOD_W:0] TOL_S   = (PERIOD_W+1)'(TOL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [PERIOD_W-1:0] r_pcnt;
    state_t              r_state;
    logic [PERIOD_W-1:0] r_ref;
    logic [COUNT_W-1:0]  r_run;
    logic                r_idle;
    logic                r_ev_valid;
    logic [PERIOD_W-1:0] r_ev_period;
    logic [COUNT_W-1:0]  r_ev_count;
    logic                r_overflow;

    logic                w_rise;
    logic                w_sil;
    logic signed [PERIOD_W:0] w_diff;
    logic                w_match;
    logic                w_close;
    logic                w_emit;
    logic [COUNT_W-1:0]  w_run_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= spk_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // The count sampled in a rise cycle is the edge-to-edge period; it then restarts at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcnt <= '0;
        end else if (w_rise) begin
            r_pcnt <= PERIOD_W'(1);
        end else if (r_pcnt != PMAX) begin
            r_pcnt <= r_pcnt + PERIOD_W'(1);
        end
    end

    assign w_sil     = (r_pcnt == SIL_VAL) && !w_rise;
    assign w_diff    = $signed({1'b0, r_pcnt}) - $signed({1'b0, r_ref});
    assign w_match   = (w_diff <= TOL_S) && (w_diff >= -TOL_S);
    assign w_run_inc = (r_run == CMAX) ? r_run : r_run + COUNT_W'(1);

    // A note closes on a period change or on silence while tracking; short runs are glitches.
    always_comb begin
        w_close = 1'b0;
        if (r_state == S_TRACK) begin
            if ((w_rise && !w_match) || w_sil) begin
                w_close = 1'b1;
            end
        end
    end

    assign w_emit = w_close && (r_run >= MIN_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ref       <= '0;
            r_run       <= '0;
            r_idle      <= 1'b1;
            r_ev_valid  <= 1'b0;
            r_ev_period <= '0;
            r_ev_count  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_ARM;
                        r_idle  <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (w_rise) begin
                        r_ref   <= r_pcnt;
                        r_run   <= COUNT_W'(1);
                        r_state <= S_TRACK;
                    end else if (w_sil) begin
                        r_state <= S_IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                S_TRACK: begin
                    if (w_rise) begin
                        if (w_match) begin
                            r_run <= w_run_inc;
                        end else begin
                            r_ref <= r_pcnt;
                            r_run <= COUNT_W'(1);
                        end
                    end else if (w_sil) begin
                        r_state <= S_IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase

            // A new note may replace an event only in the cycle the consumer takes it.
            if (w_emit) begin
                if (!r_ev_valid || ev_ready) begin
                    r_ev_valid  <= 1'b1;
                    r_ev_period <= r_ref;
                    r_ev_count  <= r_run;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_ev_valid && ev_ready) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign ev_valid  = r_ev_valid;
    assign ev_period = r_ev_period;
    assign ev_count  = r_ev_count;
    assign idle      = r_idle;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_shadow1229_tone_decoder.sv
// Directed bench for the tone decoder: table of tone patterns with expected events,
// plus hand-written sequences for latency, backpressure, overflow and mid-note reset.
module tb_shadow1229_tone_decoder;

    logic       clk;
    logic       rstN;
    logic       spkIn;
    logic       evReady;
    logic       evValid;
    logic [9:0] evPeriod;
    logic [15:0] evCount;
    logic       idle;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int perA;
        int nA;
        int perB;
        int nB;
        bit alt;
        int nExp;
        int p0;
        int c0;
        int p1;
        int c1;
    } vec_t;

    typedef struct {
        int p;
        int c;
    } ev_t;

    vec_t vecs[8];
    ev_t  evQ[$];
    int   ivals[$];

    shadow1229_tone_decoder dut (
        .clk      (clk),
        .reset    (rstN),
        .spk_in   (spkIn),
        .ev_ready (evReady),
        .ev_valid (evValid),
        .ev_period(evPeriod),
        .ev_count (evCount),
        .idle     (idle),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted events are collected on the falling edge, where the handshake is stable.
    always @(negedge clk) begin
        if (rstN && evValid && evReady) begin
            evQ.push_back('{p: int'(evPeriod), c: int'(evCount)});
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Rises spaced by ivals; returns 50 clocks after the last rise was driven.
    task automatic playIvals();
        for (int i = 0; i < ivals.size(); i++) begin
            spkIn = 1'b1;
            tick(ivals[i] / 2);
            spkIn = 1'b0;
            tick(ivals[i] - ivals[i] / 2);
        end
        spkIn = 1'b1;
        tick(50);
        spkIn = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        ivals.delete();
        if (v.alt) begin
            for (int i = 0; i < v.nA - 1; i++) ivals.push_back((i % 2 == 0) ? v.perA : v.perB);
        end else begin
            for (int i = 0; i < v.nA - 1; i++) ivals.push_back(v.perA);
            for (int j = 0; j < v.nB; j++) ivals.push_back(v.perB);
        end
        playIvals();
    endtask

    task automatic playConst(input int per, input int rises);
        ivals.delete();
        for (int i = 0; i < rises - 1; i++) ivals.push_back(per);
        playIvals();
    endtask

    initial begin
        vecs[0] = '{perA:130, nA:20, perB:0,   nB:0, alt:0, nExp:1, p0:130, c0:19, p1:0,   c1:0};
        vecs[1] = '{perA:130, nA:10, perB:66,  nB:8, alt:0, nExp:2, p0:130, c0:9,  p1:66,  c1:8};
        vecs[2] = '{perA:100, nA:12, perB:101, nB:0, alt:1, nExp:1, p0:100, c0:11, p1:0,   c1:0};
        vecs[3] = '{perA:100, nA:12, perB:102, nB:0, alt:1, nExp:0, p0:0,   c0:0,  p1:0,   c1:0};
        vecs[4] = '{perA:40,  nA:2,  perB:0,   nB:0, alt:0, nExp:0, p0:0,   c0:0,  p1:0,   c1:0};
        vecs[5] = '{perA:130, nA:5,  perB:131, nB:4, alt:0, nExp:1, p0:130, c0:8,  p1:0,   c1:0};
        vecs[6] = '{perA:130, nA:4,  perB:128, nB:4, alt:0, nExp:2, p0:130, c0:3,  p1:128, c1:4};
        vecs[7] = '{perA:50,  nA:3,  perB:0,   nB:0, alt:0, nExp:1, p0:50,  c0:2,  p1:0,   c1:0};

        rstN    = 1'b0;
        spkIn   = 1'b0;
        evReady = 1'b1;
        #23;
        checkOutput("rst_valid", int'(evValid), 0);
        checkOutput("rst_idle", int'(idle), 1);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_period", int'(evPeriod), 0);
        checkOutput("rst_count", int'(evCount), 0);
        rstN = 1'b1;
        tick(3);

        for (int v = 0; v < 8; v++) begin
            evQ.delete();
            applyStimulus(vecs[v]);
            tick(700);
            checkOutput($sformatf("v%0d_nev", v), evQ.size(), vecs[v].nExp);
            if (vecs[v].nExp >= 1 && evQ.size() >= 1) begin
                checkOutput($sformatf("v%0d_p0", v), evQ[0].p, vecs[v].p0);
                checkOutput($sformatf("v%0d_c0", v), evQ[0].c, vecs[v].c0);
            end
            if (vecs[v].nExp >= 2 && evQ.size() >= 2) begin
                checkOutput($sformatf("v%0d_p1", v), evQ[1].p, vecs[v].p1);
                checkOutput($sformatf("v%0d_c1", v), evQ[1].c, vecs[v].c1);
            end
            checkOutput($sformatf("v%0d_idle", v), int'(idle), 1);
            checkOutput($sformatf("v%0d_valid", v), int'(evValid), 0);
            checkOutput($sformatf("v%0d_ovf", v), int'(overflow), 0);
        end

        // Silence closes the note 603 clocks after the last rise is driven.
        evReady = 1'b0;
        playConst(130, 5);
        tick(552);
        checkOutput("lat_before", int'(evValid), 0);
        tick(1);
        checkOutput("lat_after", int'(evValid), 1);
        checkOutput("lat_period", int'(evPeriod), 130);
        checkOutput("lat_count", int'(evCount), 4);

        playConst(66, 4);
        tick(700);
        checkOutput("hold_valid", int'(evValid), 1);
        checkOutput("hold_period", int'(evPeriod), 130);
        checkOutput("hold_count", int'(evCount), 4);
        checkOutput("hold_overflow", int'(overflow), 1);

        evReady = 1'b1;
        tick(1);
        checkOutput("accept_valid", int'(evValid), 0);

        evReady = 1'b0;
        playConst(50, 3);
        tick(700);
        checkOutput("pend_valid", int'(evValid), 1);
        checkOutput("pend_period", int'(evPeriod), 50);
        playConst(80, 4);
        tick(552);
        evReady = 1'b1;
        tick(1);
        checkOutput("simul_valid", int'(evValid), 1);
        checkOutput("simul_period", int'(evPeriod), 80);
        checkOutput("simul_count", int'(evCount), 3);
        tick(1);
        checkOutput("simul_drain", int'(evValid), 0);

        evReady = 1'b0;
        playConst(130, 3);
        tick(700);
        checkOutput("mid_pend_valid", int'(evValid), 1);
        playConst(130, 6);
        checkOutput("mid_track_idle", int'(idle), 0);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_valid", int'(evValid), 0);
        checkOutput("mid_rst_idle", int'(idle), 1);
        checkOutput("mid_rst_ovf", int'(overflow), 0);
        tick(2);
        rstN    = 1'b1;
        evReady = 1'b1;
        tick(2);
        evQ.delete();
        applyStimulus(vecs[0]);
        tick(700);
        checkOutput("post_nev", evQ.size(), 1);
        if (evQ.size() >= 1) begin
            checkOutput("post_p", evQ[0].p, 130);
            checkOutput("post_c", evQ[0].c, 19);
        end
        checkOutput("post_idle", int'(idle), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
